// File: rtl/tap_mem_pkg.sv
// Shared definitions for the tap sample memory: readout FSM state codes and
// the legal DEPTH range.
package tap_mem_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 256;

    typedef logic [1:0] tap_state_t;

    localparam tap_state_t ST_IDLE = 2'd0;
    localparam tap_state_t ST_READ = 2'd1;
    localparam tap_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer register with load, step up/down and a combinational
// view of the slot just below the current one.
module wrap_ptr #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              dir,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] ptr_dec
);

    localparam logic [ADDR_W:0]   WRAP_AT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    logic [ADDR_W:0]   up_w;
    logic [ADDR_W:0]   dn_w;
    logic [ADDR_W-1:0] ptr_inc;

    // Wide arithmetic so wrap detection never relies on a power-of-two DEPTH.
    always_comb begin
        up_w    = {1'b0, ptr} + (ADDR_W+1)'(1);
        dn_w    = {1'b0, ptr} - (ADDR_W+1)'(1);
        ptr_inc = (up_w == WRAP_AT) ? '0 : up_w[ADDR_W-1:0];
        ptr_dec = dn_w[ADDR_W] ? LAST : dn_w[ADDR_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (step) begin
            ptr <= dir ? ptr_inc : ptr_dec;
        end
    end

endmodule

// File: rtl/tap_memory_buf.sv
// Circular tap buffer: pushes store samples, a start streams all DEPTH taps
// newest-first. Optional clear port enabled by TAP_MEMORY_CLEAR_EN.
//
// state   | meaning
// IDLE    | accepts pushes (and clear); start launches a readout
// READ    | emitting one tap per cycle, q_idx = tap age
// DONE    | single done pulse, then back to IDLE
module tap_memory_buf
    import tap_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] a,
    input  logic              start,
`ifdef TAP_MEMORY_CLEAR_EN
    input  logic              clear,
`endif
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic [ADDR_W-1:0] q_idx,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_err
        $error("tap_memory_buf: DEPTH outside the supported range");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    tap_state_t        state;
    logic              idle;
    logic              clr_cmd;
    logic              push;
    logic              start_cmd;
    logic              last_tap;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_dec;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_dec;
    logic [ADDR_W-1:0] rd_cur_unused;

`ifdef TAP_MEMORY_CLEAR_EN
    assign clr_cmd = clear && idle;
`else
    assign clr_cmd = 1'b0;
`endif

    assign idle      = (state == ST_IDLE);
    assign push      = enable && idle && !clr_cmd;
    assign start_cmd = start && idle && !clr_cmd;
    assign last_tap  = (q_idx == ADDR_W'(DEPTH - 1));
    // Tap 0 is the sample being pushed this cycle, if any.
    assign rd_base   = push ? wr_ptr : wr_dec;

    wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr_cmd),
        .load     (1'b0),
        .load_val ('0),
        .step     (push),
        .dir      (1'b1),
        .ptr      (wr_ptr),
        .ptr_dec  (wr_dec)
    );

    wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
        .clock    (clock),
        .reset    (reset),
        .clr      (1'b0),
        .load     (start_cmd),
        .load_val (rd_base),
        .step     (state == ST_READ),
        .dir      (1'b0),
        .ptr      (rd_cur_unused),
        .ptr_dec  (rd_dec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_cmd) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= a;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            q       <= '0;
            q_valid <= 1'b0;
            q_idx   <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= enable && !idle;
            done    <= 1'b0;
            if (clr_cmd) begin
                count <= '0;
            end else if (push && count != (ADDR_W+1)'(DEPTH)) begin
                count <= count + (ADDR_W+1)'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start_cmd) begin
                        state   <= ST_READ;
                        busy    <= 1'b1;
                        q_valid <= 1'b1;
                        q_idx   <= '0;
                        q       <= push ? a : mem[wr_dec];
                    end
                end
                ST_READ: begin
                    if (last_tap) begin
                        state   <= ST_DONE;
                        q_valid <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        q     <= mem[rd_dec];
                        q_idx <= q_idx + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_memory_buf.sv
// Randomised self-checking bench for tap_memory_buf (DEPTH 8 and DEPTH 5
// instances) against an age-ordered sample-list model.
`timescale 1ns/1ps
module tb_tap_memory_buf;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable_v [2];
    logic [7:0] a_v      [2];
    logic       start_v  [2];
`ifdef TAP_MEMORY_CLEAR_EN
    logic       clear_v  [2];
`endif
    logic [7:0] q_v      [2];
    logic       qv_v     [2];
    logic [2:0] qi_v     [2];
    logic       done_v   [2];
    logic       busy_v   [2];
    logic [3:0] cnt_v    [2];
    logic       ovr_v    [2];

    logic [7:0] hist   [2][8];
    int         mcount [2];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clock = ~clock;

    tap_memory_buf #(.DATA_W(8), .DEPTH(8)) u_dut8 (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable_v[0]),
        .a       (a_v[0]),
        .start   (start_v[0]),
`ifdef TAP_MEMORY_CLEAR_EN
        .clear   (clear_v[0]),
`endif
        .q       (q_v[0]),
        .q_valid (qv_v[0]),
        .q_idx   (qi_v[0]),
        .done    (done_v[0]),
        .busy    (busy_v[0]),
        .count   (cnt_v[0]),
        .overrun (ovr_v[0])
    );

    tap_memory_buf #(.DATA_W(8), .DEPTH(5)) u_dut5 (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable_v[1]),
        .a       (a_v[1]),
        .start   (start_v[1]),
`ifdef TAP_MEMORY_CLEAR_EN
        .clear   (clear_v[1]),
`endif
        .q       (q_v[1]),
        .q_valid (qv_v[1]),
        .q_idx   (qi_v[1]),
        .done    (done_v[1]),
        .busy    (busy_v[1]),
        .count   (cnt_v[1]),
        .overrun (ovr_v[1])
    );

    function automatic int depth_of(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_clear(input int d);
        for (int i = 0; i < 8; i++) hist[d][i] = 8'h00;
        mcount[d] = 0;
    endtask

    task automatic model_push(input int d, input logic [7:0] v);
        for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = v;
        if (mcount[d] < depth_of(d)) mcount[d]++;
    endtask

    task automatic check_zero(input int d, input string tag);
        check({tag, "_q"},     q_v[d],    0);
        check({tag, "_qv"},    qv_v[d],   0);
        check({tag, "_idx"},   qi_v[d],   0);
        check({tag, "_done"},  done_v[d], 0);
        check({tag, "_busy"},  busy_v[d], 0);
        check({tag, "_count"}, cnt_v[d],  0);
        check({tag, "_ovr"},   ovr_v[d],  0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check_zero(d, "rst");
            model_clear(d);
        end
        reset = 1'b1;
    endtask

    task automatic push(input int d, input logic [7:0] v);
        @(negedge clock);
        enable_v[d] = 1'b1;
        a_v[d]      = v;
        @(negedge clock);
        enable_v[d] = 1'b0;
        model_push(d, v);
        check("push_ovr", ovr_v[d], 0);
        check("push_cnt", cnt_v[d], mcount[d]);
    endtask

    // Full readout; optional same-cycle push and an optional push+start poke while busy.
    task automatic readout(input int d, input bit with_push, input logic [7:0] pv, input bit poke);
        int         n;
        int         pk;
        bit         poked_prev;
        logic [7:0] exp [8];
        n  = depth_of(d);
        pk = poke ? int'($urandom_range(n - 2, 0)) : -1;
        @(negedge clock);
        start_v[d] = 1'b1;
        if (with_push) begin
            enable_v[d] = 1'b1;
            a_v[d]      = pv;
            model_push(d, pv);
        end
        for (int i = 0; i < 8; i++) exp[i] = hist[d][i];
        poked_prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            start_v[d]  = 1'b0;
            enable_v[d] = 1'b0;
            check("rd_valid", qv_v[d],   1);
            check("rd_idx",   qi_v[d],   k);
            check("rd_q",     q_v[d],    exp[k]);
            check("rd_busy",  busy_v[d], 1);
            check("rd_done",  done_v[d], 0);
            check("rd_ovr",   ovr_v[d],  poked_prev);
            poked_prev = 1'b0;
            if (k == pk) begin
                enable_v[d] = 1'b1;
                start_v[d]  = 1'b1;
                a_v[d]      = 8'($urandom);
                poked_prev  = 1'b1;
            end
        end
        @(negedge clock);
        enable_v[d] = 1'b0;
        start_v[d]  = 1'b0;
        check("done_pulse", done_v[d], 1);
        check("done_qv",    qv_v[d],   0);
        check("done_busy",  busy_v[d], 1);
        check("done_ovr",   ovr_v[d],  poked_prev);
        check("done_qhold", q_v[d],    exp[n-1]);
        @(negedge clock);
        check("post_done",  done_v[d], 0);
        check("post_busy",  busy_v[d], 0);
        check("post_qv",    qv_v[d],   0);
        check("post_count", cnt_v[d],  mcount[d]);
        check("post_qhold", q_v[d],    exp[n-1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            enable_v[d] = 1'b0;
            a_v[d]      = 8'h00;
            start_v[d]  = 1'b0;
`ifdef TAP_MEMORY_CLEAR_EN
            clear_v[d]  = 1'b0;
`endif
            model_clear(d);
        end
        apply_reset();

        readout(0, 1'b0, 8'h00, 1'b0);

        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        readout(0, 1'b0, 8'h00, 1'b0);

        apply_reset();
        for (int v = 1; v <= 10; v++) push(0, 8'(v));
        readout(0, 1'b0, 8'h00, 1'b0);

        apply_reset();
        push(0, 8'h11);
        readout(0, 1'b1, 8'h55, 1'b0);

        readout(0, 1'b0, 8'h00, 1'b1);
        readout(0, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a readout, just after tap 3 is seen.
        @(negedge clock);
        start_v[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            start_v[0] = 1'b0;
            check("mid_idx", qi_v[0], k);
            check("mid_q",   q_v[0],  hist[0][k]);
        end
        reset = 1'b0;
        #1;
        check_zero(0, "mid_rst");
        model_clear(0);
        model_clear(1);
        @(negedge clock);
        check("mid_nodone", done_v[0], 0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_after_done", done_v[0], 0);
        check("mid_after_busy", busy_v[0], 0);

        for (int v = 1; v <= 7; v++) push(1, 8'(v));
        readout(1, 1'b0, 8'h00, 1'b0);

`ifdef TAP_MEMORY_CLEAR_EN
        push(0, 8'hA5);
        @(negedge clock);
        clear_v[0]  = 1'b1;
        enable_v[0] = 1'b1;
        start_v[0]  = 1'b1;
        a_v[0]      = 8'hEE;
        @(negedge clock);
        clear_v[0]  = 1'b0;
        enable_v[0] = 1'b0;
        start_v[0]  = 1'b0;
        model_clear(0);
        check("clr_busy",  busy_v[0], 0);
        check("clr_qv",    qv_v[0],   0);
        check("clr_count", cnt_v[0],  0);
        readout(0, 1'b0, 8'h00, 1'b0);
`endif

        for (int it = 0; it < 24; it++) begin
            int d;
            int np;
            d  = int'($urandom_range(1, 0));
            np = int'($urandom_range(12, 0));
            for (int j = 0; j < np; j++) push(d, 8'($urandom));
            readout(d, 1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tap_memory_buf.md
Name: tap_memory_buf

Overview:
- Parametrised sample memory for the adaptive filter datapath.
- Successor to the fixed 8-bit sample memory: DATA_W-wide circular tap buffer of DEPTH entries.
- Each push stores one new input sample. A start command streams all taps, newest to oldest, to the FIR/LMS MAC, one tap per cycle, with valid/index/done handshake.

Parameters:
- DATA_W, 8: sample width in bits.
- DEPTH, 8: number of taps stored; legal range 2..256, need not be a power of two.
- ADDR_W, $clog2(DEPTH): index/pointer width. Derived; do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  push strobe; samples a into the buffer this cycle.
- a  in  DATA_W  input sample.
- start  in  1  begin a tap readout.
- q  out  DATA_W  tap value, registered.
- q_valid  out  1  q and q_idx are valid this cycle.
- q_idx  out  ADDR_W  tap age; 0 is the newest sample.
- done  out  1  one-cycle pulse after the last tap is emitted.
- busy  out  1  readout in progress.
- count  out  ADDR_W+1  number of samples stored; saturates at DEPTH.
- overrun  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (async, reset=0):
  - All DEPTH entries cleared to 0; wr_ptr=0, count=0.
  - FSM goes to IDLE.
  - q=0, q_valid=0, q_idx=0, done=0, busy=0, overrun=0.
- Storage: flop array mem[0..DEPTH-1]. wr_ptr points at the next slot to write and wraps DEPTH-1 -> 0 explicitly, with no modulo-2^ADDR_W assumption.
- Push, accepted only in IDLE:
  - enable=1 -> mem[wr_ptr]<=a; wr_ptr advances with wrap.
  - count increments, saturating at DEPTH.
  - The oldest sample is silently overwritten once the buffer is full.
- Push while busy=1: dropped. Memory and count are unchanged; overrun=1 for that cycle.
- FSM states:
  - IDLE: start=1 -> READ. The read base is snapshotted as the post-push wr_ptr, so a push and start in the same IDLE cycle include the new sample as tap 0.
  - READ: k counts 0..DEPTH-1. On cycle k+1 after start: q=mem[(base-1-k) wrapped], q_idx=k, q_valid=1, busy=1. After k=DEPTH-1 -> DONE.
  - DONE: one cycle with done=1, q_valid=0, busy=1 -> IDLE.
- Timing:
  - Latency from start to first q_valid is exactly 1 cycle.
  - A full readout is DEPTH valid cycles plus 1 done cycle.
  - busy rises the cycle after start and falls the cycle after done.
- Slots never written read as 0, so with count<DEPTH the unwritten taps are 0. The readout always emits DEPTH taps.
- start while busy: ignored, with no queueing and no error flag.
- q holds its last value when q_valid=0.
- Reset asserted mid-readout aborts immediately to the reset state. No done pulse is issued.
- Width rules: no arithmetic on sample data. Pointer arithmetic uses ADDR_W+1 bits before the wrap compare.

Optional Feature:
- Macro: TAP_MEMORY_CLEAR_EN.
- Defined: adds input port clear (1 bit).
  - clear=1 in IDLE zeroes all entries, wr_ptr and count in one cycle.
  - clear has priority over enable and start in the same cycle; those are ignored that cycle.
  - clear while busy is ignored.
- Undefined: no clear port. Contents are zeroed only by reset.

Decomposition:
- Shared package tap_mem_pkg: FSM state enum {IDLE, READ, DONE}, and the DEPTH range-check constants.
- One natural sub-module: wrap_ptr, a parametrised modulo-DEPTH increment/decrement counter, used for both wr_ptr and the read address.

Test Plan:
- Reset then start (DEPTH=8, DATA_W=8) -> 8 cycles of q_valid with q=0, q_idx 0..7; done pulses on cycle 9; count=0.
- Push 1,2,3 then start -> q sequence 3,2,1,0,0,0,0,0; count=3.
- Push 0x01..0x0A (10 pushes, DEPTH=8) then start -> q 0x0A down to 0x03; count=8; wr_ptr has wrapped.
- Push 0x55 in the same cycle as start, after a prior push of 0x11 -> first q=0x55 (q_idx=0), second q=0x11.
- Push while busy -> overrun=1 for 1 cycle; the next readout is unchanged. start while busy -> ignored, and exactly one done pulse.
- Reset low at READ k=3 -> all outputs 0 asynchronously, no done. DEPTH=5 run: push 1..7 -> q 7,6,5,4,3. With TAP_MEMORY_CLEAR_EN: clear, then start -> all q=0, count=0.
